mdu: RTL and testbench

Multiply/divide unit for the execute stage of the pipelined `mips` core. It takes the forwarded execute-stage operands and the decoded multiply/divide op, and holds the architectural HI and LO registers. A multi-cycle busy window feeds the pipeline manager's stall logic. MFHI/MFLO results return combinationally for the execute-stage result mux.

---
 rtl/mdu.sv | 153 +++++++++++++++
 tb/tb_mdu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit for the execute stage: owns HI/LO, runs a fixed-length
// busy window per MULT/DIV, and serves MFHI/MFLO combinationally.
module mdu #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [3:0]  op,
    input  logic        en,
    output logic        start,
    output logic        busy,
    output logic [31:0] z,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    // Operation captured at accept; operands are held so the forwarded
    // inputs are free to change while the unit is running.
    typedef struct packed {
        logic        div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    req_t          req_q, req_nx;
    logic [31:0]   hi_r, hi_nx;
    logic [31:0]   lo_r, lo_nx;

    logic          is_md;
    logic          is_div_op;
    logic          is_sgn_op;

    assign is_md     = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_sgn_op = (op == OP_MULT) || (op == OP_DIV);

    assign busy  = (state == RUN);
    assign start = en & ~busy & is_md;
    assign hi    = hi_r;
    assign lo    = lo_r;

    always_comb begin
        z = '0;
        if (op == OP_MFHI)
            z = hi_r;
        else if (op == OP_MFLO)
            z = lo_r;
    end

    // Sign-extending both operands to 64 bits makes one unsigned multiplier
    // produce the correct low 64 bits for both MULT and MULTU.
    logic        ext_a, ext_b;
    logic [63:0] prod;

    assign ext_a = req_q.sgn & req_q.a[31];
    assign ext_b = req_q.sgn & req_q.b[31];
    assign prod  = {{32{ext_a}}, req_q.a} * {{32{ext_b}}, req_q.b};

    // Signed division done on magnitudes; the 0x80000000 / -1 case falls out
    // naturally as 0x80000000 with remainder 0.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quo, rem;

    always_comb begin
        a_neg  = req_q.sgn & req_q.a[31];
        b_neg  = req_q.sgn & req_q.b[31];
        a_mag  = a_neg ? (~req_q.a + 32'd1) : req_q.a;
        b_mag  = b_neg ? (~req_q.b + 32'd1) : req_q.b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = req_q;
        hi_nx    = hi_r;
        lo_nx    = lo_r;
        case (state)
            IDLE: begin
                if (start) begin
                    req_nx.div = is_div_op;
                    req_nx.sgn = is_sgn_op;
                    req_nx.a   = x;
                    req_nx.b   = y;
                    cnt_nx     = is_div_op ? CW'(DIV_CYC) : CW'(MULT_CYC);
                    state_nx   = RUN;
                end else if (en && (op == OP_MTHI)) begin
                    hi_nx = x;
                end else if (en && (op == OP_MTLO)) begin
                    lo_nx = x;
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = IDLE;
                    if (!req_q.div) begin
                        hi_nx = prod[63:32];
                        lo_nx = prod[31:0];
                    end else if (req_q.b != 32'd0) begin
                        hi_nx = rem;
                        lo_nx = quo;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            req_q <= req_nx;
            hi_r  <= hi_nx;
            lo_r  <= lo_nx;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops checked
// against a longint arithmetic model of HI/LO.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst;
    logic [31:0] x, y;
    logic [3:0]  op;
    logic        en;
    logic        start, busy;
    logic [31:0] z, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mh, ml;

    mdu #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .op(op), .en(en),
        .start(start), .busy(busy), .z(z), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op for one cycle and measures how long busy stays high.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic st, output int nb);
        op = o; x = a; y = b; en = 1'b1;
        #1 st = start;
        tick();
        en = 1'b0; op = 4'd0;
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            tick();
        end
    endtask

    // Architectural result of one op on the modelled HI/LO.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            4'd1: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
            4'd2: begin up = ua * ub; mh = up[63:32]; ml = up[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; ml = q[31:0]; mh = r[31:0]; end
            4'd4: if (b != 0) begin ml = a / b; mh = a % b; end
            4'd5: mh = a;
            4'd6: ml = a;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; op = 4'd0; x = '0; y = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        op = 4'd7; #1;
        checks++; if (z !== 32'd0) begin errors++; $display("FAIL reset_z got %h exp 0", z); end
        op = 4'd0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic st; int nb;
        do_op(4'd1, 32'hFFFFFFFF, 32'd2, st, nb);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start got %b exp 1", st); end
        checks++; if (nb != MC) begin errors++; $display("FAIL mult_busy got %0d exp %0d", nb, MC); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL mult_res got %h_%h exp ffffffff_fffffffe", hi, lo); end
        do_op(4'd2, 32'hFFFFFFFF, 32'd2, st, nb);
        checks++; if (nb != MC) begin errors++; $display("FAIL multu_busy got %0d exp %0d", nb, MC); end
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL multu_res got %h_%h exp 00000001_fffffffe", hi, lo); end
    endtask

    task automatic test_div();
        logic st; int nb;
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, st, nb);
        checks++; if (nb != DC) begin errors++; $display("FAIL div_busy got %0d exp %0d", nb, DC); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_res got %h_%h exp ffffffff_fffffffd", hi, lo); end
        do_op(4'd4, 32'd7, 32'd2, st, nb);
        checks++; if (hi !== 32'd1 || lo !== 32'd3) begin
            errors++; $display("FAIL divu_res got %h_%h exp 00000001_00000003", hi, lo); end
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, st, nb);
        checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
            errors++; $display("FAIL div_ovf got %h_%h exp 00000000_80000000", hi, lo); end
    endtask

    task automatic test_div_zero();
        logic st; int nb;
        do_op(4'd5, 32'h1234, 32'd0, st, nb);
        checks++; if (nb != 0 || hi !== 32'h1234) begin
            errors++; $display("FAIL mthi got hi=%h nb=%0d exp 1234 0", hi, nb); end
        do_op(4'd6, 32'h5678, 32'd0, st, nb);
        checks++; if (nb != 0 || lo !== 32'h5678) begin
            errors++; $display("FAIL mtlo got lo=%h nb=%0d exp 5678 0", lo, nb); end
        do_op(4'd4, 32'd7, 32'd0, st, nb);
        checks++; if (nb != DC) begin errors++; $display("FAIL divz_busy got %0d exp %0d", nb, DC); end
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++; $display("FAIL divz_res got %h_%h exp 00001234_00005678", hi, lo); end
        op = 4'd7; #1;
        checks++; if (z !== 32'h1234) begin errors++; $display("FAIL mfhi got %h exp 1234", z); end
        op = 4'd8; #1;
        checks++; if (z !== 32'h5678) begin errors++; $display("FAIL mflo got %h exp 5678", z); end
        op = 4'd0;
    endtask

    task automatic test_busy_ignore();
        int nb;
        op = 4'd1; x = 32'h00010000; y = 32'h00030001; en = 1'b1;
        #1;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL ign_start0 got %b exp 1", start); end
        tick();
        op = 4'd6; x = 32'hAAAA; #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL ign_start1 got %b exp 0", start); end
        tick();
        op = 4'd1; x = 32'd5; y = 32'd7; #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL ign_start2 got %b exp 0", start); end
        tick();
        en = 1'b0; op = 4'd0;
        nb = 2;
        while (busy === 1'b1 && nb < 200) begin nb++; tick(); end
        checks++; if (nb != MC) begin errors++; $display("FAIL ign_busy got %0d exp %0d", nb, MC); end
        checks++; if (hi !== 32'h3 || lo !== 32'h00010000) begin
            errors++; $display("FAIL ign_res got %h_%h exp 00000003_00010000", hi, lo); end
        op = 4'd1; x = 32'd9; y = 32'd9; en = 1'b0; #1;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL en0_start got %b exp 0", start); end
        tick();
        checks++; if (busy !== 1'b0 || lo !== 32'h00010000) begin
            errors++; $display("FAIL en0_state got busy=%b lo=%h exp 0 00010000", busy, lo); end
        op = 4'd0;
    endtask

    task automatic test_reset_mid();
        logic st; int nb;
        do_op(4'd5, 32'hBEEF, 32'd0, st, nb);
        do_op(4'd6, 32'hCAFE, 32'd0, st, nb);
        op = 4'd3; x = 32'd100; y = 32'd7; en = 1'b1;
        tick();
        en = 1'b0; op = 4'd0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", busy); end
        rst = 1'b0; #1;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL rmid_clr got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo); end
        tick();
        rst = 1'b1;
        do_op(4'd1, 32'd3, 32'd4, st, nb);
        checks++; if (st !== 1'b1 || nb != MC) begin
            errors++; $display("FAIL rmid_mult got st=%b nb=%0d exp 1 %0d", st, nb, MC); end
        checks++; if (hi !== 32'd0 || lo !== 32'd12) begin
            errors++; $display("FAIL rmid_res got %h_%h exp 00000000_0000000c", hi, lo); end
    endtask

    task automatic test_random();
        logic st; int nb, exp_nb;
        logic [3:0] o; logic [31:0] a, b;
        a = $urandom; b = $urandom;
        do_op(4'd5, a, 32'd0, st, nb);
        do_op(4'd6, b, 32'd0, st, nb);
        mh = a; ml = b;
        for (int i = 0; i < 30; i++) begin
            o = 4'($urandom_range(1, 6));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            model_op(o, a, b);
            exp_nb = (o <= 4'd2) ? MC : ((o <= 4'd4) ? DC : 0);
            do_op(o, a, b, st, nb);
            checks++; if (nb != exp_nb) begin
                errors++; $display("FAIL rnd_busy op=%0d got %0d exp %0d", o, nb, exp_nb); end
            checks++; if (hi !== mh || lo !== ml) begin
                errors++; $display("FAIL rnd_res op=%0d a=%h b=%h got %h_%h exp %h_%h",
                                   o, a, b, hi, lo, mh, ml); end
            op = 4'd7; #1;
            checks++; if (z !== mh) begin errors++; $display("FAIL rnd_mfhi got %h exp %h", z, mh); end
            op = 4'd0;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
